// File: rtl/iterative_mdu.sv
// iterative_mdu: radix-2 multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. Multiply is shift-add, divide is restoring; both take WIDTH cycles.
// Optional feature: define MDU_ABORT_EN to let the abort input kill an in-flight op.
//
// Handshake: start is a valid strobe with implicit ready = ~busy. A request is taken
// on a rising edge where start=1 and busy=0 (and abort is not suppressing it); a
// request presented while busy=1 is dropped, never queued.
module iterative_mdu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_CALC} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   // Multiply: {upper accumulator, remaining multiplier bits}.
   // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mcand;      // |a| for multiply, |b| for divide
   logic               is_div;
   logic               neg_q;      // negate product / quotient at the end
   logic               neg_r;      // negate remainder at the end
   logic               div_zero;

   logic               abort_act;
   logic               accept;
   logic               arith_go;
   logic               last_step;
   logic               signed_op;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] step_nxt;
   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0]   quo_res;
   logic [WIDTH-1:0]   rem_res;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

`ifdef MDU_ABORT_EN
   assign abort_act = abort;
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_act    = 1'b0;
`endif

   assign accept    = start & (state == S_IDLE) & ~abort_act;
   assign arith_go  = accept & ~op[2];
   assign last_step = (state == S_CALC) && (cnt == LAST_CNT);
   // mult (0) and div (2) are the signed flavours
   assign signed_op = ~op[0];
   assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (arith_go) state_nxt = S_CALC;
         S_CALC:  if (abort_act || last_step) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state == S_CALC);
   end

   // One iteration of either datapath plus the sign-corrected final results
   always_comb begin
      mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
      div_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      div_diff = div_sh - {1'b0, mcand};
      step_nxt = {mul_sum, prod[WIDTH-1:1]};
      if (is_div) begin
         // borrow out of the trial subtraction means restore the shifted remainder
         if (div_diff[WIDTH]) step_nxt = {div_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
         else                 step_nxt = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      end
      prod_res = neg_q ? -step_nxt : step_nxt;
      quo_res  = step_nxt[WIDTH-1:0];
      rem_res  = step_nxt[2*WIDTH-1:WIDTH];
      if (neg_q) quo_res = -quo_res;
      // with a zero divisor the remainder ends up as |a|, so the sign fix restores a
      if (neg_r) rem_res = -rem_res;
      if (div_zero) quo_res = {WIDTH{1'b1}};
      res_hi = is_div ? rem_res : prod_res[2*WIDTH-1:WIDTH];
      res_lo = is_div ? quo_res : prod_res[WIDTH-1:0];
   end

   // Operand capture, iteration, and HI/LO / done updates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         prod     <= '0;
         mcand    <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
            if (arith_go) begin
               cnt      <= '0;
               is_div   <= op[1];
               neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_r    <= signed_op & a[WIDTH-1];
               div_zero <= (b == '0);
               if (op[1]) begin
                  prod  <= {{WIDTH{1'b0}}, a_abs};
                  mcand <= b_abs;
               end else begin
                  prod  <= {{WIDTH{1'b0}}, b_abs};
                  mcand <= a_abs;
               end
            end
         end else if (state == S_CALC && !abort_act) begin
            prod <= step_nxt;
            cnt  <= cnt + CNT_W'(1);
            if (last_step) begin
               hi   <= res_hi;
               lo   <= res_lo;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_iterative_mdu.sv
// tb_iterative_mdu: randomized and directed bench for iterative_mdu (WIDTH=32).
// Results are predicted with plain 64-bit arithmetic and checked by a done-driven monitor.
module tb_iterative_mdu;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           start;
   logic           abort;
   logic [2:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;

   logic [2*W-1:0] exp_q[$];
   int             tests = 0;
   int             fails = 0;
   logic [W-1:0]   m_hi = '0;
   logic [W-1:0]   m_lo = '0;
   logic           prev_done = 1'b0;

   // Clock
   always #5 clk = ~clk;

   iterative_mdu #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: full-width arithmetic, {hi,lo} packed
   function automatic logic [2*W-1:0] ref_model(input logic [2:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
      longint          sx;
      longint          sy;
      longint unsigned ux;
      longint unsigned uy;
      logic [2*W-1:0]  r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      r  = '0;
      case (o)
         3'd0: r = sx * sy;
         3'd1: r = ux * uy;
         3'd2: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else        r = {32'(sx % sy), 32'(sx / sy)};
         end
         3'd3: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else        r = {32'(ux % uy), 32'(ux / uy)};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         check("done_width", {63'b0, prev_done}, '0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: got hi=%h lo=%h expected no done", hi, lo);
         end else begin
            check("result", {hi, lo}, exp_q.pop_front());
         end
      end
      prev_done = done;
   end

   // Driver: called at a negedge, issues one request and follows it through
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int poke_at, input int abort_at);
      logic [W-1:0]   old_hi;
      logic [W-1:0]   old_lo;
      logic [2*W-1:0] r;
      int             n;
      bit             hold_ok;
      old_hi  = m_hi;
      old_lo  = m_lo;
      n       = 0;
      hold_ok = 1'b1;
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      if (o <= 3'd3) begin
         r = ref_model(o, x, y);
         exp_q.push_back(r);
         m_hi = r[2*W-1:W];
         m_lo = r[W-1:0];
         while (busy && n < 200) begin
            n++;
            if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
            if (n == poke_at) begin start = 1'b1; op = 3'd0; a = $urandom; b = $urandom; end
            if (n == poke_at + 1) start = 1'b0;
            if (n == abort_at) abort = 1'b1;
            if (n == abort_at + 1) abort = 1'b0;
            @(negedge clk);
         end
         start = 1'b0;
         abort = 1'b0;
         check("busy_cycles", 64'(n), 64'(W));
         check("hold_during_calc", {63'b0, hold_ok}, 64'd1);
      end else if (o <= 3'd5) begin
         if (o == 3'd4) m_hi = x;
         else           m_lo = x;
         check("move_regs", {hi, lo}, {m_hi, m_lo});
         check("move_no_busy_done", {62'b0, busy, done}, '0);
      end else begin
         check("reserved_regs", {hi, lo}, {m_hi, m_lo});
         check("reserved_busy", {63'b0, busy}, '0);
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {60'b0, busy, done, (hi != 0), (lo != 0)}, '0);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      run_op(3'd0, 32'hFFFF_FFFE, 32'h3, 0, 0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 0, 0);
      run_op(3'd3, 32'h7, 32'h0, 0, 0);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0, 0, 0);
      run_op(3'd2, 32'h7, 32'hFFFF_FFFE, 0, 0);
      run_op(3'd7, 32'h55, 32'h66, 0, 0);

      // mthi then a mult that sees a second start while busy
      run_op(3'd4, 32'h1234, 32'h0, 0, 0);
      run_op(3'd0, 32'h0000_1111, 32'hFFFF_FFF0, 5, 0);

`ifdef MDU_ABORT_EN
      // Abort mid-multiply keeps HI/LO, no done
      run_op(3'd5, 32'h5, 32'h0, 0, 0);
      start = 1'b1; op = 3'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", {63'b0, busy}, '0);
      check("abort_regs", {hi, lo}, {m_hi, 32'h5});
      repeat (40) @(negedge clk);
      check("abort_stays_idle", {63'b0, busy}, '0);
      // Abort in idle suppresses an mthi
      abort = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      check("abort_idle_regs", {hi, lo}, {m_hi, m_lo});
`else
      // abort is ignored: the op completes normally
      run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 10);
`endif

      // Reset in the middle of a divide
      start = 1'b1; op = 3'd2; a = 32'h0000_1000; b = 32'h3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midop_reset", {62'b0, busy, done}, '0);
      check("midop_reset_regs", {hi, lo}, '0);
      m_hi = '0;
      m_lo = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Random mix of all op codes
      for (int i = 0; i < 60; i++) begin
         run_op(3'($urandom_range(0, 7)), rand_val(), rand_val(),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0, 0);
      end

      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
